axi_fb_rd_slave: RTL and testbench

AXI4 read-only responder fronting an on-chip frame-buffer memory. It answers the burst reads issued by the VGA ping-pong fetch engine (AR/R channels) and is preloaded through a simple synchronous write port. Used as the frame-buffer target in SoC integration and as the memory end of the VGA bench; one clock domain (the AXI clock).

---
 rtl/axi_fb_rd_slave.sv | 198 +++++++++++++++++++
 tb/tb_axi_fb_rd_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fb_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_fb_rd_slave
// Purpose  : AXI4 read-only responder in front of an on-chip frame-buffer
//            memory. Serves FIXED/INCR/WRAP bursts on the AR/R channels and is
//            preloaded through a synchronous single-word write port.
// Ports    : clk, resetn            - clock, async active-low reset
//            araddr_i..arvalid_i    - AR channel request
//            arready_o              - AR accept (registered)
//            rvalid_o, rready_i     - R channel handshake
//            rdata_o/rresp_o/rlast_o- R beat payload (registered)
//            we_i/waddr_i/wdata_i   - preload write port
//            busy_o                 - burst in progress
// Revision : 1.0 - initial release
// ============================================================================
module axi_fb_rd_slave #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic [1:0]                   arburst_i,
  input  logic [7:0]                   arlen_i,
  input  logic [2:0]                   arsize_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  input  logic                         we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic                         busy_o
);

  localparam int                    c_size_log2 = $clog2(DATA_WIDTH / 8);
  localparam int                    c_idx_w     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_depth     = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0]            c_fixed     = 2'b00;
  localparam logic [1:0]            c_incr      = 2'b01;
  localparam logic [1:0]            c_wrap      = 2'b10;
  localparam logic [1:0]            c_rsvd      = 2'b11;
  localparam logic [1:0]            c_okay      = 2'b00;
  localparam logic [1:0]            c_slverr    = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_arready;
  logic                    r_rvalid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_rlast;
  logic                    r_busy;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [7:0]              r_beat;
  logic [7:0]              r_len;
  logic [1:0]              r_burst;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_below;
  logic [ADDR_WIDTH-1:0]   w_ar_idx;
  logic                    w_ar_err;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic [ADDR_WIDTH-1:0]   w_len_ext;
  logic [ADDR_WIDTH-1:0]   w_adv_idx;
  logic [ADDR_WIDTH-1:0]   w_load_idx;
  logic                    w_load_err;
  logic                    w_load_bad;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [1:0]              w_load_resp;

  // An address below the base can only happen for a non-zero base; the
  // comparison is dropped otherwise so it does not degenerate to a constant.
  if (BASE_ADDR == '0) begin : g_base_zero
    assign w_below = 1'b0;
  end else begin : g_base_nonzero
    assign w_below = (araddr_i < BASE_ADDR);
  end

  // Word index discards the byte offset inside the beat.
  assign w_ar_idx = (araddr_i - BASE_ADDR) >> c_size_log2;

  // Burst-wide error: decided once at AR accept, applied to every beat.
  assign w_ar_err = (arburst_i == c_rsvd)
                 || (arsize_i != 3'(c_size_log2))
                 || ((arburst_i == c_wrap) &&
                     !(arlen_i == 8'd1 || arlen_i == 8'd3 ||
                       arlen_i == 8'd7 || arlen_i == 8'd15))
                 || w_below;

  assign w_ar_hs   = arvalid_i && r_arready;
  assign w_r_hs    = r_rvalid && rready_i;
  assign w_len_ext = ADDR_WIDTH'(r_len);

  always_comb begin
    w_adv_idx = r_idx;
    case (r_burst)
      c_fixed: w_adv_idx = r_idx;
      // Full-width increment: running past the end reports SLVERR rather
      // than wrapping back into the memory.
      c_incr:  w_adv_idx = r_idx + 1'b1;
      c_wrap:  w_adv_idx = (r_idx & ~w_len_ext) | ((r_idx + 1'b1) & w_len_ext);
      default: w_adv_idx = r_idx;
    endcase
  end

  // One shared load path: the first beat comes from the AR request, the
  // following beats from the advanced index of the running burst.
  assign w_load_idx  = (r_state == S_IDLE) ? w_ar_idx : w_adv_idx;
  assign w_load_err  = (r_state == S_IDLE) ? w_ar_err : r_err;
  assign w_load_bad  = w_load_err || (w_load_idx >= c_depth);
  assign w_load_data = w_load_bad ? '0 : r_mem[w_load_idx[c_idx_w-1:0]];
  assign w_load_resp = w_load_bad ? c_slverr : c_okay;

  // Preload port. The read above is combinational, so a beat loaded on the
  // same edge as a write to its index still sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= c_okay;
      r_rlast   <= 1'b0;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_beat    <= '0;
      r_len     <= '0;
      r_burst   <= c_fixed;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_state   <= S_BURST;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_busy    <= 1'b1;
            r_beat    <= '0;
            r_len     <= arlen_i;
            r_burst   <= arburst_i;
            r_err     <= w_ar_err;
            r_idx     <= w_ar_idx;
            r_rdata   <= w_load_data;
            r_rresp   <= w_load_resp;
            r_rlast   <= (arlen_i == 8'd0);
          end
        end
        S_BURST: begin
          if (w_r_hs) begin
            if (r_beat == r_len) begin
              r_state   <= S_IDLE;
              r_arready <= 1'b1;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_busy    <= 1'b0;
            end else begin
              // Next beat is loaded on the accepting edge: no bubble.
              r_beat  <= r_beat + 8'd1;
              r_idx   <= w_adv_idx;
              r_rdata <= w_load_data;
              r_rresp <= w_load_resp;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arready_o = r_arready;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign rlast_o   = r_rlast;
  assign busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_axi_fb_rd_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_fb_rd_slave
// Purpose  : Self-checking bench for axi_fb_rd_slave. Expected R beats are
//            pushed to a scoreboard queue when a burst is issued and popped
//            as the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_fb_rd_slave;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        resetn;
  logic [63:0] araddr_i;
  logic [1:0]  arburst_i;
  logic [7:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic        arvalid_i;
  logic        arready_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        we_i;
  logic [9:0]  waddr_i;
  logic [63:0] wdata_i;
  logic        busy_o;

  axi_fb_rd_slave dut (
    .clk       (clk),
    .resetn    (resetn),
    .araddr_i  (araddr_i),
    .arburst_i (arburst_i),
    .arlen_i   (arlen_i),
    .arsize_i  (arsize_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rlast_o   (rlast_o),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       q[$];
  logic [63:0] tb_mem [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one burst, written straight from the protocol rules.
  task automatic push_burst(input logic [63:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size);
    logic        err;
    logic        bad;
    logic [63:0] idx;
    logic [63:0] lm;
    beat_t       e;
    err = (burst == 2'b11) || (size != 3'd3) ||
          ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
    idx = addr >> 3;
    lm  = 64'(len);
    for (int b = 0; b <= len; b++) begin
      bad    = err || (idx >= 64'(DEPTH));
      e.data = bad ? 64'd0 : tb_mem[idx[9:0]];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (b == len);
      q.push_back(e);
      if (burst == 2'b01)      idx = idx + 64'd1;
      else if (burst == 2'b10) idx = (idx & ~lm) | ((idx + 64'd1) & lm);
    end
  endtask

  task automatic preload(input int k, input logic [63:0] d);
    @(negedge clk);
    we_i    = 1'b1;
    waddr_i = 10'(k);
    wdata_i = d;
    tb_mem[k] = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  // Issue one AR; optionally fire a preload write on the very same edge.
  task automatic ar_issue(input logic [63:0] addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input bit do_wr, input int widx, input logic [63:0] wdat);
    push_burst(addr, len, burst, size);
    @(negedge clk);
    check("arready_idle", 64'(arready_o), 64'd1);
    araddr_i  = addr;
    arlen_i   = 8'(len);
    arburst_i = burst;
    arsize_i  = size;
    arvalid_i = 1'b1;
    if (do_wr) begin
      we_i    = 1'b1;
      waddr_i = 10'(widx);
      wdata_i = wdat;
    end
    @(posedge clk);
    #1;
    arvalid_i = 1'b0;
    we_i      = 1'b0;
    if (do_wr) tb_mem[widx] = wdat;
    check("first_rvalid", 64'(rvalid_o), 64'd1);
    check("busy_in_burst", 64'(busy_o), 64'd1);
    check("arready_in_burst", 64'(arready_o), 64'd0);
  endtask

  // Drain the scoreboard; mode 1 toggles rready randomly.
  task automatic run_burst(input int mode, input int exp_cycles);
    int    cyc;
    bit    stalled;
    beat_t saved;
    beat_t e;
    cyc     = 0;
    stalled = 1'b0;
    saved   = '0;
    while (q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_rdata", rdata_o, saved.data);
        check("stall_rresp", 64'(rresp_o), 64'(saved.resp));
        check("stall_rlast", 64'(rlast_o), 64'(saved.last));
      end
      rready_i = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid_o && rready_i) begin
        e = q.pop_front();
        check("rdata", rdata_o, e.data);
        check("rresp", 64'(rresp_o), 64'(e.resp));
        check("rlast", 64'(rlast_o), 64'(e.last));
        stalled = 1'b0;
      end else if (rvalid_o) begin
        stalled    = 1'b1;
        saved.data = rdata_o;
        saved.resp = rresp_o;
        saved.last = rlast_o;
      end else begin
        check("rvalid_in_burst", 64'(rvalid_o), 64'd1);
        stalled = 1'b0;
      end
    end
    if (q.size() > 0) begin
      check("burst_timeout_left", 64'(q.size()), 64'd0);
      q.delete();
    end
    if (exp_cycles >= 0) check("burst_cycles", 64'(cyc), 64'(exp_cycles));
    @(posedge clk);
    #1;
    rready_i = 1'b1;
    check("idle_rvalid", 64'(rvalid_o), 64'd0);
    check("idle_arready", 64'(arready_o), 64'd1);
    check("idle_rlast", 64'(rlast_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    beat_t e;
    resetn    = 1'b0;
    araddr_i  = '0;
    arburst_i = 2'b01;
    arlen_i   = '0;
    arsize_i  = 3'd3;
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    we_i      = 1'b0;
    waddr_i   = '0;
    wdata_i   = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", 64'(arready_o), 64'd1);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_rresp", 64'(rresp_o), 64'd0);
    check("rst_rlast", 64'(rlast_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Preload mem[k] = 0x1000 + k.
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      we_i      = 1'b1;
      waddr_i   = 10'(k);
      wdata_i   = 64'h1000 + 64'(k);
      tb_mem[k] = 64'h1000 + 64'(k);
    end
    @(negedge clk);
    we_i = 1'b0;

    // INCR basic: words 8..15, eight beats in eight cycles.
    ar_issue(64'h40, 7, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    check("incr_first_word", rdata_o, 64'h1008);
    run_burst(0, 8);

    // Same burst under random backpressure.
    ar_issue(64'h40, 7, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    run_burst(1, -1);

    // WRAP from word 6, len 3: 6,7,4,5.
    ar_issue(64'h30, 3, 2'b10, 3'd3, 1'b0, 0, 64'd0);
    run_burst(0, 4);

    // FIXED at word 3, len 2.
    ar_issue(64'h18, 2, 2'b00, 3'd3, 1'b0, 0, 64'd0);
    run_burst(0, 3);

    // Error bursts.
    ar_issue(64'h40, 3, 2'b01, 3'd2, 1'b0, 0, 64'd0);
    check("err_size_resp", 64'(rresp_o), 64'd2);
    run_burst(0, 4);
    ar_issue(64'h40, 1, 2'b11, 3'd3, 1'b0, 0, 64'd0);
    run_burst(0, 2);
    ar_issue(64'h40, 2, 2'b10, 3'd3, 1'b0, 0, 64'd0);
    run_burst(1, -1);
    ar_issue(64'(1022 * 8), 3, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    run_burst(0, 4);

    // Preload collision on word 5.
    preload(5, 64'h55);
    ar_issue(64'h28, 0, 2'b01, 3'd3, 1'b1, 5, 64'hAA);
    check("collision_old", rdata_o, 64'h55);
    run_burst(0, 1);
    ar_issue(64'h28, 0, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    check("collision_new", rdata_o, 64'hAA);
    run_burst(0, 1);

    // Reset in the middle of a len 7 burst, with beat 3 on R.
    ar_issue(64'h0, 7, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rready_i = 1'b1;
      e = q.pop_front();
      check("mid_rdata", rdata_o, e.data);
    end
    @(posedge clk);
    #1;
    check("mid_beat3", rdata_o, 64'h1003);
    resetn = 1'b0;
    #1;
    check("mrst_rvalid", 64'(rvalid_o), 64'd0);
    check("mrst_rlast", 64'(rlast_o), 64'd0);
    check("mrst_rresp", 64'(rresp_o), 64'd0);
    check("mrst_rdata", rdata_o, 64'd0);
    check("mrst_arready", 64'(arready_o), 64'd1);
    check("mrst_busy", 64'(busy_o), 64'd0);
    q.delete();
    @(negedge clk);
    resetn = 1'b1;

    // Fresh burst after reset; memory contents survive reset.
    ar_issue(64'h20, 3, 2'b01, 3'd3, 1'b0, 0, 64'd0);
    run_burst(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
